// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle multiply/divide unit holding the HI/LO registers.
// Operands are latched at the start edge. HI/LO are written only at the
// completion edge (or directly by mthi/mtlo), so partial results are never
// visible on hi, lo or rd_data.
module mult_div_unit #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        rd_sel,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd_data
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam int LAT_MAX = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(LAT_MAX + 1);
  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       a_q, b_q;
  logic [2:0]        op_q;
  logic              is_mdu_op;
  logic              accept;
  logic              done;
  logic              div_by_zero;
  logic [63:0]       result;

  // Signed 32x32 product, full 64-bit result.
  function automatic logic [63:0] mul_signed(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    sa = 64'($signed(a));
    sb = 64'($signed(b));
    return sa * sb;
  endfunction

  // Unsigned 32x32 product, full 64-bit result.
  function automatic logic [63:0] mul_unsigned(input logic [31:0] a, input logic [31:0] b);
    return {32'd0, a} * {32'd0, b};
  endfunction

  // Signed divide packed as {remainder, quotient}; quotient truncates toward
  // zero and the remainder follows the dividend's sign. The one overflowing
  // case is pinned explicitly rather than left to the simulator.
  function automatic logic [63:0] div_signed(input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb, q, r;
    sa = $signed(a);
    sb = $signed(b);
    if (b == 32'd0) begin
      return 64'd0;
    end
    if ((a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
      return {32'd0, 32'h8000_0000};
    end
    q = sa / sb;
    r = sa % sb;
    return {r, q};
  endfunction

  // Unsigned divide packed as {remainder, quotient}.
  function automatic logic [63:0] div_unsigned(input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) begin
      return 64'd0;
    end
    return {a % b, a / b};
  endfunction

  // Control decodes, result selection and the externally visible comb outputs.
  always_comb begin
    is_mdu_op   = (op >= OP_MULT) && (op <= OP_DIVU);
    accept      = (state == IDLE) && start && is_mdu_op;
    done        = (state == RUN) && (cnt == CNT_ONE);
    div_by_zero = ((op_q == OP_DIV) || (op_q == OP_DIVU)) && (b_q == 32'd0);
    case (op_q)
      OP_MULT:  result = mul_signed(a_q, b_q);
      OP_MULTU: result = mul_unsigned(a_q, b_q);
      OP_DIV:   result = div_signed(a_q, b_q);
      OP_DIVU:  result = div_unsigned(a_q, b_q);
      default:  result = 64'd0;
    endcase
    stall_req = busy | (start & is_mdu_op);
    rd_data   = rd_sel ? hi : lo;
  end

  // Next-state logic: IDLE -> RUN on an accepted mult/div, RUN -> IDLE on completion.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (done)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Operand latch, latency counter and registered busy flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      busy <= 1'b0;
      a_q  <= 32'd0;
      b_q  <= 32'd0;
      op_q <= 3'd0;
    end else if (accept) begin
      a_q  <= A;
      b_q  <= B;
      op_q <= op;
      cnt  <= ((op == OP_MULT) || (op == OP_MULTU)) ? MULT_CNT : DIV_CNT;
      busy <= 1'b1;
    end else if (done) begin
      cnt  <= '0;
      busy <= 1'b0;
    end else if (state == RUN) begin
      cnt  <= cnt - CNT_ONE;
    end
  end

  // HI/LO architectural registers: written at completion or by mthi/mtlo while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= 32'd0;
      lo <= 32'd0;
    end else if (done) begin
      if (!div_by_zero) begin
        hi <= result[63:32];
        lo <= result[31:0];
      end
    end else if ((state == IDLE) && start) begin
      if (op == OP_MTHI) hi <= A;
      if (op == OP_MTLO) lo <= A;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed testbench for mult_div_unit with hand-computed expected values.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A, B;
  logic        rd_sel;
  logic        busy, stall_req;
  logic [31:0] hi, lo, rd_data;

  int checks = 0;
  int errors = 0;
  int n;

  mult_div_unit #(.MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .A         (A),
    .B         (B),
    .rd_sel    (rd_sel),
    .busy      (busy),
    .stall_req (stall_req),
    .hi        (hi),
    .lo        (lo),
    .rd_data   (rd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a mult/div, scramble A/B after the start edge, and count busy cycles.
  // When mid_mtlo is set, an mtlo of 0xDEADBEEF is attempted in the fourth busy cycle.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit mid_mtlo, output int cycles);
    op = o; A = a; B = b; start = 1'b1;
    #1;
    chk("stall_req_start", {31'd0, stall_req}, 32'd1);
    tick();
    start = 1'b0; A = 32'hA5A5_A5A5; B = 32'h0000_0003;
    cycles = 0;
    while (busy && cycles < 50) begin
      if (mid_mtlo && cycles == 3) begin
        start = 1'b1; op = 3'd6; A = 32'hDEAD_BEEF;
        #1;
        chk("stall_req_midrun", {31'd0, stall_req}, 32'd1);
      end
      cycles++;
      tick();
      start = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 3'd0; A = 32'd0; B = 32'd0; rd_sel = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_rd_lo", rd_data, 32'd0);
    rd_sel = 1'b1; #1;
    chk("reset_rd_hi", rd_data, 32'd0);

    // mult -1 * 2 = -2
    run_op(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, n);
    chk("mult_busy_cycles", n, 32'd5);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFE);
    rd_sel = 1'b0; #1;
    chk("mult_rd_lo", rd_data, 32'hFFFF_FFFE);

    // multu 0xFFFFFFFF * 2 = 0x1_FFFFFFFE
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, n);
    chk("multu_busy_cycles", n, 32'd5);
    chk("multu_hi", hi, 32'h0000_0001);
    chk("multu_lo", lo, 32'hFFFF_FFFE);

    // div -7 / 2 = -3 rem -1, with an mtlo attempted mid-run
    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b1, n);
    chk("div_busy_cycles", n, 32'd10);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    // divu 7 / 2 = 3 rem 1
    run_op(3'd4, 32'd7, 32'd2, 1'b0, n);
    chk("divu_busy_cycles", n, 32'd10);
    chk("divu_lo", lo, 32'd3);
    chk("divu_hi", hi, 32'd1);

    // div by zero leaves HI/LO alone but still takes the full latency
    run_op(3'd3, 32'd100, 32'd0, 1'b0, n);
    chk("div0_busy_cycles", n, 32'd10);
    chk("div0_hi", hi, 32'd1);
    chk("div0_lo", lo, 32'd3);

    // signed overflow 0x80000000 / -1
    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, n);
    chk("divovf_lo", lo, 32'h8000_0000);
    chk("divovf_hi", hi, 32'd0);

    // mthi
    op = 3'd5; A = 32'h1234_5678; start = 1'b1; #1;
    chk("mthi_stall_req", {31'd0, stall_req}, 32'd0);
    tick();
    start = 1'b0;
    chk("mthi_hi", hi, 32'h1234_5678);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    chk("mthi_lo_kept", lo, 32'h8000_0000);

    // mtlo
    op = 3'd6; A = 32'h0BAD_F00D; start = 1'b1;
    tick();
    start = 1'b0;
    chk("mtlo_lo", lo, 32'h0BAD_F00D);
    chk("mtlo_hi_kept", hi, 32'h1234_5678);

    // reserved op 7 has no effect
    op = 3'd7; A = 32'hFFFF_0000; start = 1'b1; #1;
    chk("op7_stall_req", {31'd0, stall_req}, 32'd0);
    tick();
    start = 1'b0;
    chk("op7_busy", {31'd0, busy}, 32'd0);
    chk("op7_hi", hi, 32'h1234_5678);
    chk("op7_lo", lo, 32'h0BAD_F00D);

    // reset in the third busy cycle of a mult discards it
    op = 3'd1; A = 32'd3; B = 32'd5; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_hi", hi, 32'd0);
    chk("rst_mid_lo", lo, 32'd0);
    for (int i = 0; i < 10; i++) tick();
    chk("rst_mid_busy_later", {31'd0, busy}, 32'd0);
    chk("rst_mid_lo_later", lo, 32'd0);
    chk("rst_mid_hi_later", hi, 32'd0);

    // reset wins over a simultaneous start
    op = 3'd4; A = 32'd9; B = 32'd4; start = 1'b1; reset = 1'b1;
    tick();
    start = 1'b0; reset = 1'b0;
    chk("rst_start_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 12; i++) tick();
    chk("rst_start_lo", lo, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle multiply/divide unit in the execute stage, directly downstream of the register file.
- Consumes the rs/rt read data (RD1/RD2) and holds the architectural HI/LO registers.
- Services mult, multu, div, divu, mthi, mtlo, mfhi and mflo.
- Reports busy so the hazard unit can stall any following MDU instruction.

Parameters:
- MULT_LAT, 5, cycles busy for mult/multu (>=1).
- DIV_LAT, 10, cycles busy for div/divu (>=1).

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin the operation in op.
- op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- A  input  32  operand from RD1 (rs).
- B  input  32  operand from RD2 (rt).
- rd_sel  input  1  0 selects LO, 1 selects HI onto rd_data.
- busy  output  1  registered; high while a mult/div is in flight.
- stall_req  output  1  combinational: busy | (start & op in 1..4).
- hi  output  32  current HI register.
- lo  output  32  current LO register.
- rd_data  output  32  combinational: rd_sel ? hi : lo (mfhi/mflo path).

Behaviour:
- Reset (sync, posedge with reset=1):
  - hi=0, lo=0, busy=0, internal counter=0, latched operands/op=0.
  - An in-flight operation is discarded and produces no HI/LO write.
  - Reset has priority over every other input.
- State machine: IDLE and RUN.
- IDLE, start=1, op in 1..4:
  - Latch A, B and op.
  - Counter <= MULT_LAT (ops 1,2) or DIV_LAT (ops 3,4).
  - busy <= 1; go to RUN.
- IDLE, start=1, op=5 (mthi): hi <= A at that edge; stay IDLE, busy stays 0.
- IDLE, start=1, op=6 (mtlo): lo <= A at that edge; stay IDLE, busy stays 0.
- IDLE, start=1, op=0 or 7: no effect.
- RUN, each posedge: counter decrements.
- RUN, posedge with counter==1:
  - Write hi/lo from the latched result.
  - busy <= 0, counter <= 0; return to IDLE.
  - busy is therefore high for exactly LAT consecutive cycles.
  - New hi/lo values are visible the cycle busy is first low.
- start during RUN (any op, including mthi/mtlo) is ignored. The hazard unit must hold the instruction via stall_req.
- Results are computed from the latched operands. Changes on A/B after the start edge have no effect.
- mult: 64-bit signed product of $signed(A) and $signed(B); hi = product[63:32], lo = product[31:0].
- multu: same split, unsigned product.
- div:
  - lo = signed quotient, truncated toward zero.
  - hi = remainder, carrying the sign of the dividend.
  - Overflow case 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- divu: lo = unsigned quotient, hi = unsigned remainder.
- Divide by zero (B==0, op 3/4): the unit still goes busy for DIV_LAT cycles; hi/lo are left unchanged at completion.
- rd_data and hi/lo outputs never show partial results; they change only at the completion edge or at an mthi/mtlo edge.
- Reset in the same cycle as start: reset wins; busy=0 next cycle.

Test Plan:
- Reset then idle: busy=0, hi=lo=0; rd_sel=0/1 -> rd_data=0.
- mult, A=0xFFFFFFFF, B=2, start 1 cycle:
  - busy=1 for 5 cycles, stall_req=1 in the start cycle.
  - Then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- multu, same operands -> after 5 cycles hi=0x00000001, lo=0xFFFFFFFE.
- div, A=0xFFFFFFF9 (-7), B=2:
  - busy 10 cycles.
  - Then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - A mtlo issued mid-run is ignored.
- divu, A=7, B=2 -> lo=3, hi=1.
- div with B=0 after the divu -> hi=1, lo=3 unchanged.
- mthi A=0x12345678 -> hi=0x12345678 next cycle, busy never set.
- Reset mid-run: mult started, reset asserted in cycle 3 -> busy=0, hi=lo=0, no later write occurs.
